// File: rtl/display_vector_packer.sv
// display_vector_packer
//   Producer side of the 42-bit six-digit seven-segment display bus.
//   Accepts an unsigned binary value over valid/ready, converts it to six
//   BCD digits with a sequential shift-add-3 (one bit per clock), encodes
//   each digit to seven segments and registers the packed vector.
//
// Ports
//   clk        system clock, rising edge
//   rstN       asynchronous active-low reset
//   valueIn    [BIN_WIDTH-1:0] unsigned value to display
//   inValid    valueIn valid this cycle
//   inReady    idle, a value is accepted on the next edge with inValid
//   vectorOut  [41:0] digit k (k=0 ones) at [41-7k -: 7], bit 6=g .. bit 0=a
//   outValid   one-cycle pulse, vectorOut updated this cycle

// Per-digit segment encoder. dash wins over blank, blank wins over digit.
module display_seg_enc #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);
  logic [6:0] raw;

  always_comb begin
    raw = 7'b0000000;
    if (dash) begin
      raw = 7'b1000000;
    end else if (!blank) begin
      case (digit)
        4'd0:    raw = 7'b0111111;
        4'd1:    raw = 7'b0000110;
        4'd2:    raw = 7'b1011011;
        4'd3:    raw = 7'b1001111;
        4'd4:    raw = 7'b1100110;
        4'd5:    raw = 7'b1101101;
        4'd6:    raw = 7'b1111101;
        4'd7:    raw = 7'b0000111;
        4'd8:    raw = 7'b1111111;
        4'd9:    raw = 7'b1101111;
        default: raw = 7'b0000000;
      endcase
    end
  end

  assign seg = ACTIVE_LOW ? ~raw : raw;
endmodule

module display_vector_packer #(
  parameter int BIN_WIDTH     = 20,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic [BIN_WIDTH-1:0] valueIn,
  input  logic                 inValid,
  output logic                 inReady,
  output logic [41:0]          vectorOut,
  output logic                 outValid
);
  localparam int          NUM_DIG = 6;
  localparam int          CW      = $clog2(BIN_WIDTH + 1);
  localparam logic [41:0] SEG_OFF = {42{ACTIVE_LOW}};

  typedef enum logic [1:0] {IDLE, CONVERT, ENCODE} state_t;

  state_t                        state;
  logic [BIN_WIDTH-1:0]          shift;
  logic [NUM_DIG-1:0][3:0]       bcd;
  logic [NUM_DIG-1:0][3:0]       adj;
  logic [23:0]                   adj_flat;
  logic [CW-1:0]                 cnt;
  logic                          ovf;
  logic [NUM_DIG-1:0]            blank;
  logic [NUM_DIG-1:0][6:0]       seg;
  logic [41:0]                   packed_vec;

  assign inReady = (state == IDLE);

  // add-3 correction ahead of each shift
  always_comb begin
    for (int i = 0; i < NUM_DIG; i++)
      adj[i] = (bcd[i] >= 4'd5) ? bcd[i] + 4'd3 : bcd[i];
  end
  assign adj_flat = adj;

  // A digit is blank when it and every higher digit is zero; ones never blank.
  always_comb begin
    blank = '0;
    blank[NUM_DIG-1] = BLANK_LEADING && (bcd[NUM_DIG-1] == 4'd0);
    for (int k = NUM_DIG - 2; k >= 1; k--)
      blank[k] = blank[k+1] && (bcd[k] == 4'd0);
  end

  genvar g;
  generate
    for (g = 0; g < NUM_DIG; g++) begin : g_dig
      display_seg_enc #(.ACTIVE_LOW(ACTIVE_LOW)) u_enc (
        .digit (bcd[g]),
        .blank (blank[g]),
        .dash  (ovf),
        .seg   (seg[g])
      );
    end
  endgenerate

  // ones digit goes to the top of the bus
  always_comb begin
    packed_vec = '0;
    for (int k = 0; k < NUM_DIG; k++)
      packed_vec[41-7*k -: 7] = seg[k];
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      shift     <= '0;
      bcd       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      vectorOut <= SEG_OFF;
      outValid  <= 1'b0;
    end else begin
      outValid <= 1'b0;
      case (state)
        IDLE: begin
          if (inValid) begin
            shift <= valueIn;
            bcd   <= '0;
            cnt   <= CW'(BIN_WIDTH);
            ovf   <= 1'b0;
            state <= CONVERT;
          end
        end
        CONVERT: begin
          // Any bit leaving the top nibble means a seventh digit exists,
          // i.e. the value exceeds 999999.
          bcd   <= {adj_flat[22:0], shift[BIN_WIDTH-1]};
          ovf   <= ovf | adj_flat[23];
          shift <= shift << 1;
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= ENCODE;
        end
        ENCODE: begin
          vectorOut <= packed_vec;
          outValid  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_display_vector_packer.sv
module tb_display_vector_packer;
  logic        clk = 1'b0;
  logic        rstN;
  // a: 20-bit, active-low, blanking; b: no blanking; c: 4-bit, active-high
  logic [19:0] vin_a, vin_b;
  logic [3:0]  vin_c;
  logic        ivld_a, ivld_b, ivld_c;
  logic        rdy_a, rdy_b, rdy_c;
  logic [41:0] vo_a, vo_b, vo_c;
  logic        ov_a, ov_b, ov_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  display_vector_packer #(.BIN_WIDTH(20), .ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) u_a (
    .clk(clk), .rstN(rstN), .valueIn(vin_a), .inValid(ivld_a),
    .inReady(rdy_a), .vectorOut(vo_a), .outValid(ov_a));
  display_vector_packer #(.BIN_WIDTH(20), .ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)) u_b (
    .clk(clk), .rstN(rstN), .valueIn(vin_b), .inValid(ivld_b),
    .inReady(rdy_b), .vectorOut(vo_b), .outValid(ov_b));
  display_vector_packer #(.BIN_WIDTH(4), .ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b1)) u_c (
    .clk(clk), .rstN(rstN), .valueIn(vin_c), .inValid(ivld_c),
    .inReady(rdy_c), .vectorOut(vo_c), .outValid(ov_c));

  function automatic logic get_ov(input int sel);
    case (sel)
      0: return ov_a;
      1: return ov_b;
      default: return ov_c;
    endcase
  endfunction

  function automatic logic get_rdy(input int sel);
    case (sel)
      0: return rdy_a;
      1: return rdy_b;
      default: return rdy_c;
    endcase
  endfunction

  function automatic logic [41:0] get_vo(input int sel);
    case (sel)
      0: return vo_a;
      1: return vo_b;
      default: return vo_c;
    endcase
  endfunction

  task automatic drive(input int sel, input logic [19:0] v, input logic en);
    case (sel)
      0: begin vin_a = v; ivld_a = en; end
      1: begin vin_b = v; ivld_b = en; end
      default: begin vin_c = v[3:0]; ivld_c = en; end
    endcase
  endtask

  // One transaction: lat = edges from accept to outValid (-1 on timeout),
  // busy = inReady just after the accepting edge.
  task automatic run(input int sel, input logic [19:0] v,
                     output int lat, output logic [41:0] vec, output logic busy);
    @(negedge clk);
    drive(sel, v, 1'b1);
    @(posedge clk); #1;
    drive(sel, v, 1'b0);
    busy = get_rdy(sel);
    lat = -1;
    vec = '0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (get_ov(sel)) begin
        lat = i;
        vec = get_vo(sel);
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    #12;
    @(negedge clk);
    n_tests++;
    if (vo_a !== 42'h3FF_FFFF_FFFF) begin n_fail++; $display("FAIL reset_vec_a got %h exp %h", vo_a, 42'h3FF_FFFF_FFFF); end
    n_tests++;
    if (ov_a !== 1'b0 || rdy_a !== 1'b1) begin n_fail++; $display("FAIL reset_hs_a got ov=%b rdy=%b exp ov=0 rdy=1", ov_a, rdy_a); end
    n_tests++;
    if (vo_c !== 42'h0) begin n_fail++; $display("FAIL reset_vec_c got %h exp 0", vo_c); end
    rstN = 1'b1;
  endtask

  task automatic test_basic();
    int lat; logic [41:0] vec; logic busy;
    run(0, 20'd123456, lat, vec, busy);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_123456 got inReady=%b exp 0", busy); end
    n_tests++;
    if (lat !== 21) begin n_fail++; $display("FAIL lat_123456 got %0d exp 21", lat); end
    n_tests++;
    if (vec !== {7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79}) begin
      n_fail++; $display("FAIL vec_123456 got %h exp %h", vec, {7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79});
    end
    @(posedge clk); #1;
    n_tests++;
    if (ov_a !== 1'b0 || vo_a !== vec) begin n_fail++; $display("FAIL pulse_hold got ov=%b vec=%h exp ov=0 vec=%h", ov_a, vo_a, vec); end
  endtask

  task automatic test_blanking();
    int lat; logic [41:0] vec; logic busy;
    run(0, 20'd0, lat, vec, busy);
    n_tests++;
    if (vec !== {7'h40, {5{7'h7F}}}) begin n_fail++; $display("FAIL vec_0 got %h exp %h", vec, {7'h40, {5{7'h7F}}}); end
    run(0, 20'd42, lat, vec, busy);
    n_tests++;
    if (vec !== {7'h24, 7'h19, {4{7'h7F}}}) begin n_fail++; $display("FAIL vec_42 got %h exp %h", vec, {7'h24, 7'h19, {4{7'h7F}}}); end
    run(1, 20'd42, lat, vec, busy);
    n_tests++;
    if (vec !== {7'h24, 7'h19, {4{7'h40}}}) begin n_fail++; $display("FAIL vec_42_noblank got %h exp %h", vec, {7'h24, 7'h19, {4{7'h40}}}); end
    // inner zeros stay lit under leading-blank
    run(0, 20'd100203, lat, vec, busy);
    n_tests++;
    if (vec !== {7'h30, 7'h40, 7'h24, 7'h40, 7'h40, 7'h79}) begin
      n_fail++; $display("FAIL vec_100203 got %h exp %h", vec, {7'h30, 7'h40, 7'h24, 7'h40, 7'h40, 7'h79});
    end
  endtask

  task automatic test_overflow();
    int lat; logic [41:0] vec; logic busy;
    run(0, 20'd999999, lat, vec, busy);
    n_tests++;
    if (vec !== {6{7'h10}}) begin n_fail++; $display("FAIL vec_999999 got %h exp %h", vec, {6{7'h10}}); end
    run(0, 20'd1000000, lat, vec, busy);
    n_tests++;
    if (vec !== {6{7'h3F}}) begin n_fail++; $display("FAIL vec_1000000 got %h exp %h", vec, {6{7'h3F}}); end
    run(0, 20'hFFFFF, lat, vec, busy);
    n_tests++;
    if (vec !== {6{7'h3F}}) begin n_fail++; $display("FAIL vec_fffff got %h exp %h", vec, {6{7'h3F}}); end
    // dash must not stick once a legal value follows
    run(0, 20'd7, lat, vec, busy);
    n_tests++;
    if (vec !== {7'h78, {5{7'h7F}}}) begin n_fail++; $display("FAIL vec_7_after_ovf got %h exp %h", vec, {7'h78, {5{7'h7F}}}); end
  endtask

  task automatic test_back_to_back();
    int t1, t2; logic [41:0] v1, v2; logic rdy_ov;
    t1 = -1; t2 = -1; v1 = '0; v2 = '0; rdy_ov = 1'b0;
    @(negedge clk);
    vin_a = 20'd5; ivld_a = 1'b1;
    @(posedge clk); #1;
    vin_a = 20'd7;                     // stays asserted through the conversion
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (ov_a) begin t1 = i; v1 = vo_a; rdy_ov = rdy_a; break; end
    end
    vin_a = 20'd8;                     // offered in the outValid cycle
    @(posedge clk); #1;
    ivld_a = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (ov_a) begin t2 = i + 1; v2 = vo_a; break; end
    end
    n_tests++;
    if (t1 !== 21 || v1 !== {7'h12, {5{7'h7F}}}) begin
      n_fail++; $display("FAIL b2b_first got lat=%0d vec=%h exp lat=21 vec=%h", t1, v1, {7'h12, {5{7'h7F}}});
    end
    n_tests++;
    if (rdy_ov !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b exp 1", rdy_ov); end
    n_tests++;
    if (t2 !== 22 || v2 !== {7'h00, {5{7'h7F}}}) begin
      n_fail++; $display("FAIL b2b_second got gap=%0d vec=%h exp gap=22 vec=%h", t2, v2, {7'h00, {5{7'h7F}}});
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    vin_a = 20'd123456; ivld_a = 1'b1;
    @(posedge clk); #1;
    ivld_a = 1'b0;
    repeat (5) @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    n_tests++;
    if (vo_a !== 42'h3FF_FFFF_FFFF || ov_a !== 1'b0 || rdy_a !== 1'b1) begin
      n_fail++; $display("FAIL midreset got vec=%h ov=%b rdy=%b exp vec=3ffffffffff ov=0 rdy=1", vo_a, ov_a, rdy_a);
    end
    @(negedge clk);
    rstN = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (ov_a) seen++;
    end
    n_tests++;
    if (seen !== 0) begin n_fail++; $display("FAIL midreset_nopulse got %0d pulses exp 0", seen); end
  endtask

  task automatic test_param_sweep();
    int lat; logic [41:0] vec; logic busy;
    run(2, 20'd9, lat, vec, busy);
    n_tests++;
    if (lat !== 5) begin n_fail++; $display("FAIL lat_w4 got %0d exp 5", lat); end
    n_tests++;
    if (vec !== {7'h6F, 35'h0}) begin n_fail++; $display("FAIL vec_w4_9 got %h exp %h", vec, {7'h6F, 35'h0}); end
  endtask

  initial begin
    vin_a = '0; vin_b = '0; vin_c = '0;
    ivld_a = 1'b0; ivld_b = 1'b0; ivld_c = 1'b0;
    test_reset();
    test_basic();
    test_blanking();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/display_vector_packer.md
Name: display_vector_packer

Overview:
- Producer side of the 42-bit six-digit seven-segment display bus consumed by the display unpacker.
- Accepts an unsigned binary value over a valid/ready handshake.
- Converts the value to six BCD digits with a sequential shift-add-3 (double-dabble), one bit per clock.
- Encodes each digit to seven segments and registers the packed 42-bit vector for the board HEX displays.

Parameters:
- BIN_WIDTH, 20, width of binary input; legal range 1..20.
- ACTIVE_LOW, 1, 1 = segment lit when bit is 0 (DE-series HEX); 0 = active-high.
- BLANK_LEADING, 1, 1 = blank leading zero digits; 0 = show all six digits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rstN  input  1  asynchronous active-low reset.
- valueIn  input  BIN_WIDTH  unsigned value to display.
- inValid  input  1  valueIn is valid this cycle.
- inReady  output  1  block is idle and accepts a value.
- vectorOut  output  42  packed segments: digit k (k=0 is ones) occupies [41-7k -: 7]; within each digit, bit 6 = g … bit 0 = a.
- outValid  output  1  one-cycle pulse: vectorOut updated this cycle.

Behaviour:
- Reset, asynchronous on rstN low: state IDLE, inReady=1, outValid=0, vectorOut = all segments off (42 ones if ACTIVE_LOW, else 42 zeros), internal shift/BCD registers cleared.
- Reset mid-conversion aborts the conversion; no outValid is produced.
- States:
  - IDLE: inReady=1. On an edge with inValid=1, latch valueIn, clear the 24-bit BCD register, load counter = BIN_WIDTH, go to CONVERT.
  - CONVERT: one iteration per cycle. Every BCD nibble ≥5 gets +3, then {bcd, shift} shifts left by 1 and the counter decrements. When the counter reaches 0 after the final shift, go to ENCODE. Occupies exactly BIN_WIDTH cycles.
  - ENCODE: one cycle. Encode the six nibbles, apply blanking/overflow, register into vectorOut, pulse outValid, return to IDLE at the same edge.
- Latency: the accepting edge is E0. vectorOut and outValid update at edge E0+BIN_WIDTH+1. outValid is high for exactly one cycle.
- inReady is high in that cycle, so a new value may be accepted while outValid=1. Back-to-back throughput is one value per BIN_WIDTH+2 cycles.
- inValid while not IDLE is ignored; the value is neither queued nor able to corrupt the conversion in flight.
- vectorOut holds its last value between updates.
- Encoding, active-high abcdefg shown as bits g..a:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - blank=0000000, dash=1000000
  - ACTIVE_LOW inverts all seven bits.
- Leading blanking (BLANK_LEADING=1): a digit k≥1 is blank when it and all higher digits are zero. Digit 0 is never blanked, so value 0 shows "0".
- Overflow: latched value >999999 (reachable only when BIN_WIDTH=20) → all six digits show dash; the blanking rule does not apply.
- Values narrower than 20 bits are zero-extended. No arithmetic wraps, since the 24-bit BCD register covers 0..999999.
- Clocked logic is asynchronously reset only; no latches; all outputs are registered except inReady, which is decoded from the state register.

Test Plan:
- Reset: hold rstN=0 → vectorOut=42'h3FF_FFFF_FFFF, outValid=0, inReady=1. Assert rstN low again during CONVERT → same values, no outValid pulse afterwards.
- valueIn=123456, inValid one cycle (ACTIVE_LOW=1) → outValid exactly 21 edges after the accepting edge. vectorOut = {7'h02,7'h12,7'h19,7'h30,7'h24,7'h79} (digits 6,5,4,3,2,1 from bit 41 down). inReady=0 during conversion.
- valueIn=0 with BLANK_LEADING=1 → digit0=7'h40, digits1..5=7'h7F. valueIn=42 → {7'h24,7'h19,7'h7F,7'h7F,7'h7F,7'h7F}. Rerun 42 with BLANK_LEADING=0 → digits2..5=7'h40.
- valueIn=999999 → all digits 7'h10. valueIn=1000000 → all digits 7'h3F (dash). valueIn=20'hFFFFF → all dash.
- Second inValid (value 7) held during an in-flight conversion of 5 → ignored; output shows 5 only. Then inValid=1 with value 8 in the outValid cycle → accepted. Next outValid 22 cycles after the first, with digit0=7'h00.
- Parameter sweep: BIN_WIDTH=4, ACTIVE_LOW=0, valueIn=9 → outValid 5 edges after accept, digit0=7'h6F, digits1..5=7'h00.
